// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipeline hazard unit
package pipe_pkg;

  // Register index width held in the shadow slots; the top's REG_ADDR_W must not exceed it.
  localparam int REG_AW = 5;

  // EX operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Shadow copy of one in-flight instruction's register usage.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic              reg_write;
    logic              mem_read;
  } hz_slot_t;

  localparam hz_slot_t HZ_BUBBLE = '0;

  // True when the slot will write register r; x0 is never a real destination.
  function automatic logic slot_writes(hz_slot_t s, logic [REG_AW-1:0] r);
    return s.valid & s.reg_write & (s.rd == r) & (r != '0);
  endfunction

  // Operand source for register r: the younger MEM producer wins over WB.
  function automatic fwd_sel_e fwd_pick(hz_slot_t mem_s, hz_slot_t wb_s,
                                        logic [REG_AW-1:0] r);
    if (slot_writes(mem_s, r)) begin
      return FWD_MEM;
    end else if (slot_writes(wb_s, r)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with async active-low reset
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step by one unless already at all-ones, so the value never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall/flush/forward control for the 5-stage pipeline; PIPE_FORWARDING_EN enables EX operand forwarding
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_valid,
  input  logic                  ex_redirect,
  input  logic                  ext_stall,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // ID fields widened to the slot index width.
  logic [REG_AW-1:0] id_rs1_w;
  logic [REG_AW-1:0] id_rs2_w;
  logic [REG_AW-1:0] id_rd_w;

  assign id_rs1_w = REG_AW'(id_rs1);
  assign id_rs2_w = REG_AW'(id_rs2);
  assign id_rd_w  = REG_AW'(id_rd);

  hz_slot_t ex_q,  ex_d;
  hz_slot_t mem_q, mem_d;
  hz_slot_t wb_q,  wb_d;

  logic     id_reads_ex_rd;
  logic     load_use;
  logic     raw;
  logic     hz_stall;
  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;

  // Load in EX whose destination the ID instruction needs: data only exists after MEM.
  always_comb begin
    id_reads_ex_rd = (id_use_rs1 && (id_rs1_w == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2_w == ex_q.rd));
    load_use       = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_reads_ex_rd;
  end

`ifdef PIPE_FORWARDING_EN
  // Forwarding covers every ALU dependency, so only load-use has to stall.
  always_comb begin
    raw       = 1'b0;
    fwd_a_sel = fwd_pick(mem_q, wb_q, ex_q.rs1);
    fwd_b_sel = fwd_pick(mem_q, wb_q, ex_q.rs2);
  end
`else
  // No bypass paths: wait until a producer is in WB, where the write-first file serves it.
  always_comb begin
    raw       = (id_use_rs1 && (slot_writes(ex_q, id_rs1_w) || slot_writes(mem_q, id_rs1_w))) ||
                (id_use_rs2 && (slot_writes(ex_q, id_rs2_w) || slot_writes(mem_q, id_rs2_w)));
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
  end
`endif

  // A redirect kills the ID instruction anyway, so it overrides any data hazard.
  always_comb begin
    hz_stall = (load_use || raw) && id_valid && !ex_redirect;
  end

  // Shadow pipeline advance; ext_stall freezes everything, stalls/redirects inject a bubble into EX.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!ext_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (hz_stall || ex_redirect || !id_valid) begin
        ex_d = HZ_BUBBLE;
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.rd        = id_rd_w;
        ex_d.rs1       = id_rs1_w;
        ex_d.rs2       = id_rs2_w;
        ex_d.use_rs1   = id_use_rs1;
        ex_d.use_rs2   = id_use_rs2;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
      end
    end
  end

  // Slot registers; reset leaves every slot empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= HZ_BUBBLE;
      mem_q <= HZ_BUBBLE;
      wb_q  <= HZ_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign stall_pc   = hz_stall || ext_stall;
  assign stall_ifid = hz_stall || ext_stall;
  assign flush_ifid = ex_redirect && !ext_stall;
  assign flush_idex = (ex_redirect || hz_stall) && !ext_stall;
  assign fwd_a      = fwd_a_sel;
  assign fwd_b      = fwd_b_sel;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (hz_stall && !ext_stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (flush_ifid),
    .cnt   (flush_cnt)
  );

  // Slot fields kept for observability but not read in every build.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_q, mem_q.rs1, mem_q.rs2, mem_q.use_rs1, mem_q.use_rs2,
                              mem_q.mem_read, ex_q.use_rs1, ex_q.use_rs2, ex_q.rs1, ex_q.rs2};

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_use_rs1 = 1'b0;
  logic       id_use_rs2 = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       id_valid = 1'b0;
  logic       ex_redirect = 1'b0;
  logic       ext_stall = 1'b0;
  logic       stall_pc, stall_ifid, flush_ifid, flush_idex;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt, flush_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  pipe_hazard_unit #(
    .REG_ADDR_W (5),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_valid     (id_valid),
    .ex_redirect  (ex_redirect),
    .ext_stall    (ext_stall),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic set_nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // lw x5,0(x1)
  task automatic set_lw_x5();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
  endtask

  // add x6,x5,x2
  task automatic set_add_x5();
    set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ex_redirect = 1'b0;
    ext_stall = 1'b0;
    set_nop();
    step();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    step();
    #1;
    chk("rst_stall_pc", stall_pc, 0);
    chk("rst_flush_idex", flush_idex, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b1;

    // Load-use: lw x5 then add x6,x5,x2
    do_reset();
    set_lw_x5();
    #1 chk("lu_lw_stall", stall_pc, 0);
    step();
    set_add_x5();
    #1;
    chk("lu_stall_pc", stall_pc, 1);
    chk("lu_stall_ifid", stall_ifid, 1);
    chk("lu_flush_idex", flush_idex, 1);
    chk("lu_flush_ifid", flush_ifid, 0);
    step();
`ifdef PIPE_FORWARDING_EN
    #1 chk("lu_stall_c2", stall_pc, 0);
`else
    #1 chk("lu_stall_c2", stall_pc, 1);
    step();
    #1 chk("lu_stall_c3", stall_pc, 0);
`endif
    step();
    set_nop();
    #1;
`ifdef PIPE_FORWARDING_EN
    chk("lu_fwd_a", fwd_a, 2'b01);
    chk("lu_stall_cnt", stall_cnt, 1);
`else
    chk("lu_fwd_a", fwd_a, 2'b00);
    chk("lu_stall_cnt", stall_cnt, 2);
`endif
    chk("lu_fwd_b", fwd_b, 2'b00);

    // ALU RAW: addi x5,x0,3 then add x6,x5,x5
    do_reset();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
`ifdef PIPE_FORWARDING_EN
    #1 chk("raw_stall", stall_pc, 0);
    step();
    set_nop();
    #1;
    chk("raw_fwd_a", fwd_a, 2'b10);
    chk("raw_fwd_b", fwd_b, 2'b10);
    chk("raw_stall_cnt", stall_cnt, 0);
`else
    #1 chk("raw_stall_ex", stall_pc, 1);
    step();
    #1 chk("raw_stall_mem", stall_pc, 1);
    step();
    #1 chk("raw_stall_wb", stall_pc, 0);
    step();
    set_nop();
    #1;
    chk("raw_fwd_a", fwd_a, 2'b00);
    chk("raw_fwd_b", fwd_b, 2'b00);
    chk("raw_stall_cnt", stall_cnt, 2);
`endif

    // x0 producer and consumer
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    #1 chk("x0_stall", stall_pc, 0);
    step();
    set_nop();
    #1;
    chk("x0_fwd_a", fwd_a, 2'b00);
    chk("x0_fwd_b", fwd_b, 2'b00);

    // Redirect together with load-use
    do_reset();
    set_lw_x5();
    step();
    set_add_x5();
    ex_redirect = 1'b1;
    #1;
    chk("rd_flush_ifid", flush_ifid, 1);
    chk("rd_flush_idex", flush_idex, 1);
    chk("rd_stall_pc", stall_pc, 0);
    step();
    ex_redirect = 1'b0;
    set_nop();
    #1;
    chk("rd_flush_cnt", flush_cnt, 1);
    chk("rd_stall_cnt", stall_cnt, 0);

    // ext_stall for 3 cycles over a pending load-use
    do_reset();
    set_lw_x5();
    step();
    set_add_x5();
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("es_stall_pc", stall_pc, 1);
      chk("es_flush_idex", flush_idex, 0);
      chk("es_flush_ifid", flush_ifid, 0);
      step();
    end
    ext_stall = 1'b0;
    #1;
    chk("es_rel_stall", stall_pc, 1);
    chk("es_rel_flush_idex", flush_idex, 1);
    chk("es_stall_cnt0", stall_cnt, 0);
    chk("es_flush_cnt0", flush_cnt, 0);
    step();
    #1 chk("es_stall_cnt1", stall_cnt, 1);

    // Counter saturation at 15 with CNT_W=4
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_lw_x5();
      step();
      set_add_x5();
      step();
    end
    #1 chk("sat_cnt15", stall_cnt, 15);
    set_lw_x5();
    step();
    set_add_x5();
    #1 chk("sat_stall16", stall_pc, 1);
    step();
    #1;
    chk("sat_hold15", stall_cnt, 15);
    chk("sat_flush_cnt", flush_cnt, 0);

    // Async reset in the middle of a stall
    set_lw_x5();
    step();
    set_add_x5();
    #1 chk("ar_pre_stall", stall_pc, 1);
    rst = 1'b0;
    #1;
    chk("ar_stall_pc", stall_pc, 0);
    chk("ar_flush_idex", flush_idex, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
    chk("ar_flush_cnt", flush_cnt, 0);
    chk("ar_fwd_a", fwd_a, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ar_rel_stall", stall_pc, 0);
    step();
    #1;
    chk("ar_post_stall", stall_pc, 0);
    chk("ar_post_flush", flush_ifid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Hazard and forwarding controller for the 5-stage pipelined successor of the single-cycle `cpu` top. It keeps a shadow record of the destination and source registers in the EX, MEM and WB stages, driven from ID-stage decode fields. From this it generates stall, flush and forwarding controls for the pipeline registers and ALU operand muxes. It sits beside the pipeline registers in the new top and also provides saturating stall and flush performance counters.

## Interface
Parameters:
- `REG_ADDR_W`, 5: register index width; register 0 is hard-wired zero.
- `CNT_W`, 32: width of each performance counter.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in `REG_ADDR_W`: source indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: ID instruction actually reads rs1/rs2.
- `id_rd` in `REG_ADDR_W`: destination index of the ID instruction.
- `id_reg_write`, `id_mem_read` in 1: ID instruction writes the register file / is a load.
- `id_valid` in 1: the ID slot holds a real instruction.
- `ex_redirect` in 1: branch or jump resolved taken in EX this cycle.
- `ext_stall` in 1: memory not ready; the whole pipeline freezes.
- `stall_pc`, `stall_ifid` out 1: hold PC and the IF/ID register.
- `flush_ifid`, `flush_idex` out 1: replace the IF/ID and ID/EX contents with a bubble.
- `fwd_a`, `fwd_b` out 2: EX operand select; 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
- `stall_cnt`, `flush_cnt` out `CNT_W`: performance counters.

## Operation
- The shadow pipeline has slots EX, MEM and WB. Each slot holds {valid, rd, rs1, rs2, use_rs1, use_rs2, reg_write, mem_read}.
- The slot update rule applies on each rising edge with `ext_stall`=0:
  - MEM takes EX, and WB takes MEM.
  - EX takes the ID fields gated by `id_valid`.
  - EX takes a bubble (valid=0) if `hz_stall` or `ex_redirect` is set.
- With `ext_stall`=1, every slot holds its value.
- A slot "writes r" when valid & reg_write & rd==r & r!=0.
- Load-use hazard: EX slot valid & mem_read & rd!=0, and the ID instruction reads that register (rs1 with use_rs1, or rs2 with use_rs2).
- RAW hazard: defined in Configuration.
- `hz_stall` = (load-use | RAW) & `id_valid` & !`ex_redirect`.
- Output equations:
  - `stall_pc` = `stall_ifid` = `hz_stall` | `ext_stall`.
  - `flush_ifid` = `ex_redirect` & !`ext_stall`.
  - `flush_idex` = (`ex_redirect` | `hz_stall`) & !`ext_stall`.
- Priority, highest first: `ext_stall`, then `ex_redirect`, then `hz_stall`.
- A redirect raised during `ext_stall` is held by upstream logic until `ext_stall` drops. It then takes effect in the first cycle with `ext_stall`=0.
- Counters:
  - `stall_cnt` increments on each cycle with `hz_stall`=1 and `ext_stall`=0.
  - `flush_cnt` increments on each cycle with `flush_ifid`=1.
  - Both saturate at all-ones; there is no wrap.
- The register file is write-first, so a WB-stage producer never stalls ID.

## Timing
- Reset: all slots are invalid, `stall_cnt`=`flush_cnt`=0, and every combinational output evaluates to 0 (`fwd_a`=`fwd_b`=00).
- Stall, flush and forward outputs are combinational from the current slots and ID inputs, with zero latency. Slots and counters update on the rising edge.
- Load-use with forwarding costs exactly 1 stall cycle.
- Without forwarding, a dependency on the EX slot costs 2 cycles and a dependency on the MEM slot costs 1 cycle.
- Reset asserted mid-stall clears all slots immediately. No stall or flush is asserted in the first cycle after release unless the inputs demand it.

## Configuration
- `PIPE_FORWARDING_EN` defined:
  - `fwd_a` = 10 if the MEM slot writes EX.rs1, else 01 if the WB slot writes EX.rs1, else 00. `fwd_b` is the same for EX.rs2.
  - The MEM slot has priority over WB.
  - RAW = 0, so only the load-use hazard stalls.
- `PIPE_FORWARDING_EN` undefined:
  - `fwd_a` = `fwd_b` = 00 constantly.
  - RAW = the EX or MEM slot writes a register the ID instruction reads.

## Structure
- Package `pipe_pkg` holds:
  - the `fwd_sel_e` enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10);
  - the `hz_slot_t` packed struct.
- Sub-module `sat_counter` (parameter `CNT_W`, input inc, async active-low reset) is instantiated twice for the performance counters.

## Test plan
- Sequence `lw x5,0(x1)` then `add x6,x5,x2`, forwarding on → `stall_pc`=1 and `flush_idex`=1 for exactly 1 cycle. Next cycle `fwd_a`=01. `stall_cnt`=1.
- Sequence `addi x5,x0,3` then `add x6,x5,x5`, forwarding on → no stall, `fwd_a`=`fwd_b`=10. With forwarding off → 2 stall cycles, `fwd`=00.
- Producer writes x0, consumer reads x0 → no stall, `fwd_a`=00 in both configurations.
- `ex_redirect`=1 in the same cycle as a load-use hazard → `flush_ifid`=`flush_idex`=1, `stall_pc`=0, `flush_cnt`=1, `stall_cnt` unchanged.
- `ext_stall`=1 for 3 cycles during a pending load-use → slots frozen, no flushes, counters unchanged. The 1-cycle stall occurs after the release.
- Preload `stall_cnt` near all-ones (`CNT_W`=4, 16 hazard cycles) → `stall_cnt` holds at 15. Then pulse `rst` low → all counters and outputs read 0 asynchronously.
